// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Shares one external combinational Booth multiplier among NREQ
//               requesters. Round-robin grant by default; defining
//               BOOTH_ARB_FIXED_PRIO_EN switches to lowest-index-wins.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_m,
    input  logic [NREQ*WIDTH-1:0]      req_q,
    output logic [WIDTH-1:0]           mul_M,
    output logic [WIDTH-1:0]           mul_q,
    input  logic [2*WIDTH-1:0]         mul_z,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_z,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NREQ-1:0]    w_cand;
    logic [NREQ-1:0]    w_onehot;
    logic [IDW-1:0]     w_win;
    logic               w_grant;
    logic [WIDTH-1:0]   w_sel_m;
    logic [WIDTH-1:0]   w_sel_q;
    logic [WIDTH-1:0]   r_op_m;
    logic [WIDTH-1:0]   r_op_q;
    logic [IDW-1:0]     r_id;
    logic [2*WIDTH-1:0] r_rsp_z;

`ifdef BOOTH_ARB_FIXED_PRIO_EN
    assign w_cand = req_valid;
`else
    logic [IDW-1:0]  r_rr_ptr;
    logic [NREQ-1:0] w_hi;

    // Requesters at or above the pointer take precedence; wrap to the full set otherwise.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign w_hi[gi] = req_valid[gi] && (IDW'(gi) >= r_rr_ptr);
    end

    assign w_cand = (|w_hi) ? w_hi : req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
        end
    end
`endif

    always_comb begin
        w_win    = '0;
        w_onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win    = IDW'(i);
                w_onehot = NREQ'(1) << i;
            end
        end
    end

    always_comb begin
        w_sel_m = '0;
        w_sel_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) begin
                w_sel_m = req_m[i*WIDTH +: WIDTH];
                w_sel_q = req_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst_n so no grant leaks out while reset is held.
    assign w_grant   = rst_n && (r_state == S_IDLE) && (|req_valid);
    assign req_ready = w_grant ? w_onehot : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)   w_state_nxt = S_MUL;
            S_MUL:                  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_m  <= '0;
            r_op_q  <= '0;
            r_id    <= '0;
            r_rsp_z <= '0;
        end else begin
            if (w_grant) begin
                r_op_m <= w_sel_m;
                r_op_q <= w_sel_q;
                r_id   <= w_win;
            end
            if (r_state == S_MUL) begin
                r_rsp_z <= mul_z;
            end
        end
    end

    // Operand registers only change on a grant, so the multiplier inputs stay quiet otherwise.
    assign mul_M     = r_op_m;
    assign mul_q     = r_op_q;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_z     = r_rsp_z;
    assign rsp_id    = r_id;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Sequential controller that shares one combinational 32-bit Booth multiplier (signed M × q → 64-bit z) among several requesters. It selects a requester by round-robin, registers its operands, drives them into the external multiplier for one cycle, and captures the product. The product is then held in a response register until the consumer accepts it. The block sits between operand producers and the single multiplier instance, so only one multiplier is needed in the design.

## Interface
Parameters:
- NREQ, 4: number of requesters (2–8).
- WIDTH, 32: operand width. The product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot operand accept. At most one bit is high.
- req_m  in  NREQ*WIDTH  multiplicands. Requester i uses slice [i*WIDTH +: WIDTH]. Signed.
- req_q  in  NREQ*WIDTH  multipliers, same slicing. Signed.
- mul_M  out  WIDTH  operand to the multiplier M input.
- mul_q  out  WIDTH  operand to the multiplier q input.
- mul_z  in  2*WIDTH  product returned from the multiplier z output.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_z  out  2*WIDTH  signed product.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns rsp_z.
- busy  out  1  high in every state except IDLE.

## Operation
State machine: IDLE → MUL → RESP → IDLE.

- **IDLE**
  - If any req_valid bit is high, the arbiter selects winner w. It asserts req_ready[w] combinationally in the same cycle.
  - On the edge: req_m[w] and req_q[w] are latched into the operand registers, id_reg is set to w, and the state moves to MUL.
  - If no req_valid bit is high, the block stays in IDLE.
- **MUL**
  - mul_M and mul_q are driven from the operand registers.
  - On the edge: mul_z is captured into rsp_z, and the state moves to RESP.
- **RESP**
  - rsp_valid = 1 and rsp_id = id_reg. rsp_z holds its value.
  - When rsp_ready = 1 on the edge, the state returns to IDLE.
  - No grant is issued in RESP.
- **Round-robin:** a pointer rr_ptr selects the search start. The search scans rr_ptr, rr_ptr+1, … mod NREQ, and the first valid requester wins. On a grant, rr_ptr ← (w+1) mod NREQ.
- **Arithmetic:** two's complement throughout. The product is full width with no truncation.
- mul_M and mul_q keep their last values outside MUL, so the multiplier inputs do not toggle needlessly.
- req_ready is never asserted outside IDLE. A requester that deasserts req_valid before it is granted is simply not granted; nothing is lost.

## Timing
- **Reset values:**
  - state = IDLE, rr_ptr = 0
  - req_ready = 0, rsp_valid = 0, rsp_z = 0, rsp_id = 0
  - mul_M = 0, mul_q = 0, busy = 0
- **Latency:** grant in cycle N; MUL in cycle N+1; rsp_valid high from cycle N+2.
- **Throughput:** at most one operation every 3 cycles. The next grant comes no earlier than the cycle after the rsp handshake.
- **Backpressure:** while rsp_ready = 0, rsp_valid, rsp_z and rsp_id stay stable and all req_ready bits stay 0.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losing requesters hold req_valid and are served in rotation.
- **Reset mid-operation:** asserting rst_n low in MUL or RESP aborts the operation and discards the result. All outputs return to their reset values immediately (asynchronously).
- **Multiplier timing:** mul_z must settle within one clk period of mul_M/mul_q changing.

## Configuration
- **BOOTH_ARB_FIXED_PRIO_EN defined:** fixed priority. The lowest index always wins, and rr_ptr is not implemented.
- **Macro undefined (default):** round-robin as described above.

## Test plan
- **Single request:** requester 0 sends 30 × 21 → req_ready[0] high in the grant cycle; rsp_valid high 2 cycles later with rsp_z = 630, rsp_id = 0.
- **Signed operands:** requester 2 sends M = -3, q = 11 → rsp_z = 64'hFFFF_FFFF_FFFF_FFDF (-33), rsp_id = 2.
- **Contention:** requesters 1 and 3 both send continuously, starting from reset → grants in order 1, 3, 1, 3. Each response id matches its products (32 × 2 = 64 for requester 1, 13 × 27 = 351 for requester 3).
- **Backpressure:** hold rsp_ready = 0 for 5 cycles after rsp_valid rises (3 × 4) → rsp_z stays 12, rsp_valid stays 1, all req_ready stay 0, busy stays 1. The next grant comes one cycle after rsp_ready goes high.
- **Reset mid-operation:** assert rst_n = 0 during MUL of 31 × 40 → rsp_valid = 0 and rsp_z = 0 immediately. After release, no stale response appears and the next request completes normally.
- **BOOTH_ARB_FIXED_PRIO_EN defined:** requesters 0 and 2 both send continuously → requester 0 is granted every time and requester 2 is never granted while requester 0 is valid.
